int_ctrl: RTL and testbench

//  Parametrised external-interrupt controller on the RIB bus, ahead of the core's int_flag_i.

---
 rtl/int_ctrl_pkg.sv | 24 ++
 rtl/int_prio_sel.sv | 27 ++
 rtl/int_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_int_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the external-interrupt controller.
package int_ctrl_pkg;

  localparam int unsigned INT_W = 8;
  localparam logic [INT_W-1:0] INT_ASSERT = 8'h01;
  localparam logic [INT_W-1:0] INT_NONE   = 8'h00;

  localparam int unsigned ID_W = 5;

  localparam logic [11:0] INT_CTRL_PENDING   = 12'h000;
  localparam logic [11:0] INT_CTRL_ENABLE    = 12'h004;
  localparam logic [11:0] INT_CTRL_MODE      = 12'h008;
  localparam logic [11:0] INT_CTRL_THRESHOLD = 12'h00C;
  localparam logic [11:0] INT_CTRL_CLAIM     = 12'h010;
  localparam logic [11:0] INT_CTRL_COMPLETE  = 12'h014;
  localparam logic [9:0]  INT_CTRL_PRIO_WORD = 10'h008;

  typedef enum logic [1:0] {
    INT_ST_IDLE    = 2'd0,
    INT_ST_ASSERT  = 2'd1,
    INT_ST_SERVICE = 2'd2
  } int_state_e;

endpackage

// File: rtl/int_prio_sel.sv
// Combinational max-priority selector; ties resolve to the lowest ID.
module int_prio_sel
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic [NUM_SRC-1:0]             eligible,
  input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio,
  output logic [ID_W-1:0]                best
);

  logic [PRIO_W-1:0] best_prio;

  // Scan upward with strict compare so an equal priority never displaces a lower ID
  always_comb begin
    best      = '0;
    best_prio = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (prio[i] > best_prio)) begin
        best_prio = prio[i];
        best      = ID_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// External-interrupt controller: source synchronisers, RIB registers, claim/complete FSM.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned PRIO_W      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic              wr_en_i,
  input  logic [31:0]       wr_addr_i,
  input  logic [31:0]       wr_data_i,
  input  logic [31:0]       rd_addr_i,
  output logic [31:0]       rd_data_o,
  output logic [INT_W-1:0]  int_flag_o,
  output logic [ID_W-1:0]   int_id_o
);

  logic [NUM_SRC-1:0]             sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0]             synced, synced_d, rise;
  logic [NUM_SRC-1:0]             pend_q, pend_d, pending;
  logic [NUM_SRC-1:0]             enable_q, mode_q, eligible;
  logic [PRIO_W-1:0]              thr_q;
  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q;
  logic [ID_W-1:0]                best, id_q, id_d, claimed_q, claimed_d;
  int_state_e                     state_q, state_d;

  logic        wr_hit, rd_hit, wr_prio;
  logic [11:0] wr_off, rd_off;
  logic        claim_hit, claim_ok, complete_ok;
  logic [NUM_SRC-1:0] claim_clr;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~synced_d;
  // Edge-mode bits come from the sticky register, level-mode bits straight from the synced line
  assign pending = (pend_q & mode_q) | (synced & ~mode_q);

  // Eligibility uses current (pre-write) register values
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      eligible[i] = pending[i] & enable_q[i] & (prio_q[i] > thr_q);
    end
  end

  int_prio_sel #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W)
  ) u_prio_sel (
    .eligible (eligible),
    .prio     (prio_q),
    .best     (best)
  );

  assign wr_hit  = wr_en_i && (wr_addr_i[31:12] == BASE_ADDR[31:12]);
  assign wr_off  = wr_addr_i[11:0];
  assign rd_hit  = (rd_addr_i[31:12] == BASE_ADDR[31:12]);
  assign rd_off  = rd_addr_i[11:0];
  assign wr_prio = wr_hit && (wr_off[1:0] == 2'b00) &&
                   (wr_off[11:2] >= INT_CTRL_PRIO_WORD) &&
                   (wr_off[11:2] < (INT_CTRL_PRIO_WORD + 10'(NUM_SRC)));

  // Match the full write word against each ID so out-of-range IDs never claim
  always_comb begin
    claim_hit = 1'b0;
    claim_clr = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (wr_data_i == 32'(i + 1)) begin
        claim_hit    = eligible[i];
        claim_clr[i] = mode_q[i];
      end
    end
  end

  assign claim_ok    = (state_q == INT_ST_ASSERT) && wr_hit &&
                       (wr_off == INT_CTRL_CLAIM) && claim_hit;
  assign complete_ok = (state_q == INT_ST_SERVICE) && wr_hit &&
                       (wr_off == INT_CTRL_COMPLETE) && (wr_data_i == 32'(claimed_q));

  // Source synchroniser chain plus previous synced value for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      synced_d <= '0;
    end else begin
      sync_q[0] <= src_i;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      synced_d <= synced;
    end
  end

  // Edge pending next-state: clears first, then sets, so a coincident edge survives a W1C
  always_comb begin
    pend_d = pend_q;
    if (wr_hit && (wr_off == INT_CTRL_PENDING)) pend_d = pend_d & ~(wr_data_i[NUM_SRC-1:0] & mode_q);
    if (claim_ok) pend_d = pend_d & ~claim_clr;
    pend_d = pend_d | (rise & mode_q);
  end

  // Pending state and configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      enable_q <= '0;
      mode_q   <= '0;
      thr_q    <= '0;
      prio_q   <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr_hit && (wr_off == INT_CTRL_ENABLE))    enable_q <= wr_data_i[NUM_SRC-1:0];
      if (wr_hit && (wr_off == INT_CTRL_MODE))      mode_q   <= wr_data_i[NUM_SRC-1:0];
      if (wr_hit && (wr_off == INT_CTRL_THRESHOLD)) thr_q    <= wr_data_i[PRIO_W-1:0];
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (wr_prio && (wr_off[11:2] == (INT_CTRL_PRIO_WORD + 10'(i)))) prio_q[i] <= wr_data_i[PRIO_W-1:0];
      end
    end
  end

  // FSM state, asserted/serviced ID and claimed ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INT_ST_IDLE;
      id_q      <= '0;
      claimed_q <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      claimed_q <= claimed_d;
    end
  end

  // FSM next-state: assert on best, retarget while asserted, hold while in service
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    claimed_d = claimed_q;
    case (state_q)
      INT_ST_IDLE: begin
        if (best != '0) begin
          state_d = INT_ST_ASSERT;
          id_d    = best;
        end
      end
      INT_ST_ASSERT: begin
        if (claim_ok) begin
          state_d   = INT_ST_SERVICE;
          claimed_d = wr_data_i[ID_W-1:0];
          id_d      = wr_data_i[ID_W-1:0];
        end else if (best == '0) begin
          state_d = INT_ST_IDLE;
          id_d    = '0;
        end else begin
          id_d = best;
        end
      end
      INT_ST_SERVICE: begin
        if (complete_ok) begin
          state_d   = INT_ST_IDLE;
          id_d      = '0;
          claimed_d = '0;
        end
      end
      default: begin
        state_d   = INT_ST_IDLE;
        id_d      = '0;
        claimed_d = '0;
      end
    endcase
  end

  assign int_flag_o = (state_q == INT_ST_ASSERT) ? INT_ASSERT : INT_NONE;
  assign int_id_o   = id_q;

  // Combinational register read mux; unmapped offsets and unused bits read 0
  always_comb begin
    rd_data_o = '0;
    if (rd_hit) begin
      case (rd_off)
        INT_CTRL_PENDING:   rd_data_o[NUM_SRC-1:0] = pending;
        INT_CTRL_ENABLE:    rd_data_o[NUM_SRC-1:0] = enable_q;
        INT_CTRL_MODE:      rd_data_o[NUM_SRC-1:0] = mode_q;
        INT_CTRL_THRESHOLD: rd_data_o[PRIO_W-1:0]  = thr_q;
        INT_CTRL_CLAIM:     rd_data_o[ID_W-1:0]    = best;
        default: begin
          for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if ((rd_off[1:0] == 2'b00) && (rd_off[11:2] == (INT_CTRL_PRIO_WORD + 10'(i))))
              rd_data_o[PRIO_W-1:0] = prio_q[i];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed testbench for int_ctrl with hand-computed expectations.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  src;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [7:0]  int_flag;
  logic [4:0]  int_id;

  int checks = 0;
  int errors = 0;

  int_ctrl #(
    .NUM_SRC     (8),
    .PRIO_W      (3),
    .SYNC_STAGES (2),
    .BASE_ADDR   (32'h4000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_i      (src),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .int_flag_o (int_flag),
    .int_id_o   (int_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle write: drive now, let one posedge take it, release at the next negedge
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic wreg(input logic [11:0] off, input logic [31:0] data);
    wr(BASE + 32'(off), data);
  endtask

  task automatic chk_rd(input string tag, input logic [11:0] off, input logic [31:0] exp);
    rd_addr = BASE + 32'(off);
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] flag, input logic [4:0] id);
    check({tag, "_flag"}, 32'(int_flag), 32'(flag));
    check({tag, "_id"}, 32'(int_id), 32'(id));
  endtask

  initial begin
    rst_n = 1'b0; src = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    tick(3);
    chk_out("reset", 8'h00, 5'd0);
    chk_rd("reset_pending", 12'h000, 32'h0);
    chk_rd("reset_mode", 12'h008, 32'h0);
    rst_n = 1'b1;
    tick(1);

    // 1: edge source 3, prio 5, threshold 0
    wreg(12'h008, 32'hFF);
    wreg(12'h004, 32'hFF);
    wreg(12'h028, 32'd5);
    chk_rd("prio3_rb", 12'h028, 32'd5);
    src[2] = 1'b1;
    tick(2);
    chk_rd("t1_pend_early", 12'h000, 32'h00);
    tick(1);
    src[2] = 1'b0;
    chk_rd("t1_pend", 12'h000, 32'h04);
    check("t1_flag_early", 32'(int_flag), 32'(INT_NONE));
    tick(1);
    chk_out("t1_assert", INT_ASSERT, 5'd3);
    chk_rd("t1_claim_rd", 12'h010, 32'd3);

    // 3: claim / complete handshake
    wreg(12'h010, 32'd3);
    chk_out("t3_service", INT_NONE, 5'd3);
    chk_rd("t3_pend_clr", 12'h000, 32'h00);
    wreg(12'h014, 32'd4);
    chk_out("t3_bad_complete", INT_NONE, 5'd3);
    src[2] = 1'b1;
    tick(3);
    src[2] = 1'b0;
    chk_rd("t3_pend_acc", 12'h000, 32'h04);
    check("t3_no_nest", 32'(int_flag), 32'(INT_NONE));
    wreg(12'h014, 32'd3);
    chk_out("t3_idle", INT_NONE, 5'd0);
    tick(1);
    chk_out("t3_reassert", INT_ASSERT, 5'd3);
    wreg(12'h010, 32'd3);
    wreg(12'h014, 32'd3);
    tick(1);
    chk_out("t3_clean", INT_NONE, 5'd0);

    // 2: tie break, retarget, threshold drop
    wreg(12'h024, 32'd4);
    wreg(12'h030, 32'd4);
    src[1] = 1'b1; src[4] = 1'b1;
    tick(3);
    src[1] = 1'b0; src[4] = 1'b0;
    chk_rd("t2_pend", 12'h000, 32'h12);
    tick(1);
    chk_out("t2_tie", INT_ASSERT, 5'd2);
    wreg(12'h030, 32'd6);
    tick(1);
    chk_out("t2_retarget", INT_ASSERT, 5'd5);
    wreg(12'h00C, 32'd6);
    tick(1);
    chk_out("t2_thr", INT_NONE, 5'd0);
    chk_rd("t2_claim_none", 12'h010, 32'd0);
    wreg(12'h000, 32'h12);
    wreg(12'h00C, 32'd0);
    tick(1);
    chk_out("t2_clean", INT_NONE, 5'd0);

    // 4: level source 1
    wreg(12'h008, 32'hFE);
    wreg(12'h020, 32'd1);
    src[0] = 1'b1;
    tick(2);
    chk_rd("t4_level_pend", 12'h000, 32'h01);
    tick(1);
    chk_out("t4_assert", INT_ASSERT, 5'd1);
    wreg(12'h000, 32'h01);
    chk_rd("t4_w1c_level", 12'h000, 32'h01);
    check("t4_still_id", 32'(int_id), 32'd1);
    src[0] = 1'b0;
    tick(2);
    chk_rd("t4_level_drop", 12'h000, 32'h00);
    tick(1);
    chk_out("t4_idle", INT_NONE, 5'd0);
    wreg(12'h008, 32'hFF);

    // 5: set beats W1C, unmapped writes
    wreg(12'h004, 32'h00);
    src[2] = 1'b1;
    tick(2);
    wreg(12'h000, 32'h04);
    src[2] = 1'b0;
    chk_rd("t5_set_wins", 12'h000, 32'h04);
    wreg(12'h000, 32'h04);
    chk_rd("t5_w1c", 12'h000, 32'h00);
    wreg(12'h018, 32'hFFFF_FFFF);
    chk_rd("t5_rd_18", 12'h018, 32'h0);
    chk_rd("t5_en_keep", 12'h004, 32'h0);
    wreg(12'h040, 32'd7);
    chk_rd("t5_prio9", 12'h040, 32'h0);
    wr(32'h4000_1004, 32'hFF);
    chk_rd("t5_other_base", 12'h004, 32'h0);
    chk_rd("t5_prio5_keep", 12'h030, 32'd6);

    // 6: reset mid-service
    wreg(12'h004, 32'hFF);
    src[2] = 1'b1;
    tick(3);
    src[2] = 1'b0;
    tick(1);
    wreg(12'h010, 32'd3);
    src[4] = 1'b1;
    tick(3);
    src[4] = 1'b0;
    chk_out("t6_service", INT_NONE, 5'd3);
    chk_rd("t6_pend_acc", 12'h000, 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("t6_async_rst", INT_NONE, 5'd0);
    chk_rd("t6_rst_pend", 12'h000, 32'h0);
    chk_rd("t6_rst_en", 12'h004, 32'h0);
    chk_rd("t6_rst_prio", 12'h028, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    wreg(12'h008, 32'hFF);
    wreg(12'h004, 32'hFF);
    wreg(12'h028, 32'd5);
    tick(4);
    chk_rd("t6_no_pend", 12'h000, 32'h0);
    chk_out("t6_quiet", INT_NONE, 5'd0);
    src[2] = 1'b1;
    tick(3);
    src[2] = 1'b0;
    tick(1);
    chk_out("t6_new_edge", INT_ASSERT, 5'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
